// File: rtl/aes_byte_stream_loader.sv
// aes_byte_stream_loader: byte-serial load, settle, capture and byte-serial send around a combinational AES-128 core
module aes_byte_stream_loader #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_byte,
  input  logic         in_is_key,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [0:127] core_data,
  output logic [0:127] core_key,
  input  logic [0:127] core_en,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);
  typedef enum logic [1:0] {LOAD, SETTLE, SEND} state_t;
  state_t state, state_nx;
  logic [0:127] data_reg, key_reg, out_reg;
  logic [4:0] data_cnt, key_cnt, out_cnt, data_cnt_nx, key_cnt_nx;
  logic [3:0] settle_cnt;
  logic take_d, take_k, settle_done, out_hs;
  always_comb begin
    in_ready = (state == LOAD) && rst_n;
    out_valid = state == SEND;
    busy = state != LOAD;
    out_byte = out_reg[0:7];
    core_data = data_reg;
    core_key = key_reg;
    take_d = in_valid && in_ready && !in_is_key && data_cnt < 5'd16;
    take_k = in_valid && in_ready && in_is_key && key_cnt < 5'd16;
    data_cnt_nx = data_cnt + 5'(take_d);
    key_cnt_nx = key_cnt + 5'(take_k);
    settle_done = state == SETTLE && settle_cnt == 4'(SETTLE_CYCLES - 1);
    out_hs = out_valid && out_ready;
    state_nx = state == LOAD   ? ((data_cnt_nx == 5'd16 && key_cnt_nx == 5'd16) ? SETTLE : LOAD) :
               state == SETTLE ? (settle_done ? SEND : SETTLE) :
                                 ((out_hs && out_cnt == 5'd15) ? LOAD : SEND);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      data_reg <= '0;
      key_reg <= '0;
      out_reg <= '0;
      data_cnt <= '0;
      key_cnt <= '0;
      out_cnt <= '0;
      settle_cnt <= '0;
    end else begin
      state <= state_nx;
      if (take_d) data_reg <= {data_reg[8:127], in_byte};
      if (take_k) key_reg <= {key_reg[8:127], in_byte};
      data_cnt <= settle_done ? 5'd0 : data_cnt_nx;
      key_cnt <= settle_done ? 5'd0 : key_cnt_nx;
      settle_cnt <= state == SETTLE ? settle_cnt + 4'd1 : 4'd0;
      out_reg <= settle_done ? core_en : out_hs ? {out_reg[8:127], 8'h00} : out_reg;
      out_cnt <= settle_done ? 5'd0 : out_cnt + 5'(out_hs);
    end
  end
endmodule
